// File: rtl/alu_div_pkg.sv
// Shared constants, FSM state type and result-formatting helper for the divider.
package alu_div_pkg;

    localparam int XLEN  = 64;
    localparam int HALF  = 32;
    localparam int CNT_W = 7;

    // Index of the final iteration for doubleword and word operations.
    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Select quotient or remainder, apply sign correction in the op width,
    // force an all-ones quotient for a zero divisor, sign-extend word results.
    function automatic logic [XLEN-1:0] div_finalize(
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input logic            word,
        input logic            rem_sel,
        input logic            nq,
        input logic            nr,
        input logic            dz
    );
        logic [XLEN-1:0] v;
        if (rem_sel) begin
            v = nr ? (~r + XLEN'(1)) : r;
        end else if (dz) begin
            v = '1;
        end else begin
            v = nq ? (~q + XLEN'(1)) : q;
        end
        if (word) begin
            v = {{HALF{v[HALF-1]}}, v[HALF-1:0]};
        end
        return v;
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial subtract,
// keep the difference when it does not borrow.
module alu_div_step
    import alu_div_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic            bit_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The shifted partial remainder needs one extra bit before the compare.
    always_comb begin
        shifted  = {rem, bit_in};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[XLEN];
        rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/alu_div.sv
// Iterative restoring divider fed by the sign stage's magnitudes and sign flags.
// Handshake: an operation is taken on a rising edge with in_valid && in_ready
// (in_ready only in IDLE); a result is handed over on a rising edge with
// out_valid && out_ready (out_valid only in DONE). flush beats both.
module alu_div
    import alu_div_pkg::*;
#(
    parameter bit FAST_ZERO = 1'b1
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_word,
    input  logic            is_rem,
    input  logic            is_signed,
    input  logic [XLEN-1:0] mag_a,
    input  logic [XLEN-1:0] mag_b,
    input  logic [HALF-1:0] mag_aw,
    input  logic [HALF-1:0] mag_bw,
    input  logic            neg_q,
    input  logic            neg_r,
    input  logic            neg_qw,
    input  logic            neg_rw,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output state_t          fsm_state
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvs_q;
    logic             word_q;
    logic             rem_sel_q;
    logic             nq_q;
    logic             nr_q;
    logic             dz_q;

    logic [XLEN-1:0]  a_in;
    logic [XLEN-1:0]  b_in;
    logic [XLEN-1:0]  quo_init;
    logic             dz_in;
    logic             nq_in;
    logic             nr_in;
    logic [XLEN-1:0]  fz_result;

    logic [XLEN-1:0]  rem_nxt;
    logic             q_bit;
    logic [XLEN-1:0]  quo_nxt;
    logic             last;
    logic [XLEN-1:0]  calc_result;

    assign fsm_state = state_q;

    // Operand selection at acceptance; word dividends sit in the upper half so
    // their MSB is shifted out first.
    always_comb begin
        a_in      = is_word ? {{HALF{1'b0}}, mag_aw} : mag_a;
        b_in      = is_word ? {{HALF{1'b0}}, mag_bw} : mag_b;
        quo_init  = is_word ? {mag_aw, {HALF{1'b0}}} : mag_a;
        dz_in     = (b_in == '0);
        nq_in     = is_signed & (is_word ? neg_qw : neg_q);
        nr_in     = is_signed & (is_word ? neg_rw : neg_r);
        fz_result = div_finalize('1, a_in, is_word, is_rem, nq_in, nr_in, 1'b1);
    end

    alu_div_step u_step (
        .rem      (rem_q),
        .bit_in   (quo_q[XLEN-1]),
        .divisor  (dvs_q),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    // Next quotient/dividend shift register and the formatted final result.
    always_comb begin
        quo_nxt     = {quo_q[XLEN-2:0], q_bit};
        last        = (cnt_q == (word_q ? LAST_W : LAST_D));
        calc_result = div_finalize(quo_nxt, rem_nxt, word_q, rem_sel_q, nq_q, nr_q, dz_q);
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result    <= '0;
            word_q    <= 1'b0;
            rem_sel_q <= 1'b0;
            nq_q      <= 1'b0;
            nr_q      <= 1'b0;
            dz_q      <= 1'b0;
        end else if (flush) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        word_q    <= is_word;
                        rem_sel_q <= is_rem;
                        nq_q      <= nq_in;
                        nr_q      <= nr_in;
                        dz_q      <= dz_in;
                        dvs_q     <= b_in;
                        rem_q     <= '0;
                        quo_q     <= quo_init;
                        cnt_q     <= '0;
                        in_ready  <= 1'b0;
                        if (FAST_ZERO && dz_in) begin
                            state_q   <= DONE;
                            out_valid <= 1'b1;
                            result    <= fz_result;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last) begin
                        state_q   <= DONE;
                        out_valid <= 1'b1;
                        result    <= calc_result;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_div.md
ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 SHALL have parameter FAST_ZERO, default 1, meaning a zero divisor bypasses iteration and completes in 1 cycle.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-005 SHALL have port in_valid  input  1  operands and op flags valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have ports is_word, is_rem, is_signed  input  1 each  32-bit op, remainder (else quotient), signed op.
REQ-008 SHALL have ports mag_a, mag_b  input  64  dividend/divisor magnitudes from sign stage (raw values when unsigned).
REQ-009 SHALL have ports mag_aw, mag_bw  input  32  word dividend/divisor magnitudes.
REQ-010 SHALL have ports neg_q, neg_r, neg_qw, neg_rw  input  1 each  negate quotient/remainder (64-bit and word).
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  64  final quotient or remainder.

Function
REQ-014 SHALL implement FSM IDLE, CALC, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-015 SHALL accept an operation on the edge where in_valid && in_ready; all inputs latched then, ignored afterwards.
REQ-016 SHALL iterate restoring division, one quotient bit per cycle, N=64 (is_word=0) or N=32 (is_word=1) CALC cycles.
REQ-017 SHALL raise out_valid after the Nth edge following the acceptance edge (latency N cycles).
REQ-018 SHALL, with FAST_ZERO=1 and a zero divisor (mag_b, or mag_bw when is_word), go IDLE->DONE on the acceptance edge.
REQ-019 SHALL gate all neg_* flags with is_signed; unsigned ops never negate.
REQ-020 SHALL negate quotient when neg_q (neg_qw for word) and remainder when neg_r (neg_rw), two's complement, in the width of the op.
REQ-021 SHALL force quotient to all-ones (before word sign-extension) on zero divisor regardless of neg flags; remainder = sign-corrected dividend (original dividend).
REQ-022 SHALL produce signed overflow (MIN / -1) naturally: quotient = MIN, remainder = 0, no special case.
REQ-023 SHALL sign-extend bit 31 of the 32-bit result to 64 bits for word ops, signed or unsigned.
REQ-024 SHALL hold result and out_valid stable in DONE until out_ready; on out_valid && out_ready return to IDLE next edge.
REQ-025 SHALL not accept a new operation in the same cycle the previous result is consumed (one idle cycle minimum).
REQ-026 SHALL, on flush in any state, return to IDLE next edge, drop the operation, deassert out_valid; flush overrides in_valid and out_ready.
REQ-027 SHALL keep result constant outside DONE (last value or zero after reset).

Reset
REQ-028 SHALL, on reset assertion, immediately enter IDLE, clear counter, remainder, quotient and result registers to 0; out_valid=0, in_ready=1.
REQ-029 SHALL abort any CALC/DONE operation on reset mid-operation with no result emitted after release.

Structure
REQ-030 SHALL place FSM state enum, XLEN=64, HALF=32 and iteration-count constants in the shared common package.
REQ-031 SHALL use one sub-module alu_div_step: combinational single restoring step (shift, trial subtract, quotient bit).
REQ-032 SHALL be the sole consumer of the sign stage magnitude/sign outputs; no local magnitude conversion.

Verification
REQ-033 SHALL test signed DIV -7/2: mag_a=7, mag_b=2, neg_q=1 -> result 0xFFFFFFFFFFFFFFFD, out_valid 64 cycles after acceptance.
REQ-034 SHALL test signed REM -7%2: neg_r=1 -> result 0xFFFFFFFFFFFFFFFF; DIVW 100/7 -> 0x000000000000000E after 32 cycles.
REQ-035 SHALL test zero divisor: DIVW mag_aw=5, mag_bw=0 -> 0xFFFFFFFFFFFFFFFF 1 cycle after acceptance; REMU 0x1234/0 -> 0x1234.
REQ-036 SHALL test overflow: mag_a=0x8000000000000000, mag_b=1, neg_q=0 -> DIV 0x8000000000000000, REM 0.
REQ-037 SHALL test backpressure: out_ready low 10 cycles -> result/out_valid stable, in_ready=0 throughout.
REQ-038 SHALL test flush at CALC cycle 20 and reset at cycle 30 -> IDLE next edge (immediately for reset), no out_valid, next op correct.
